gcd_arbiter: RTL and testbench
==============================

GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 SHALL have parameter W, default 4, giving the operand and result width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have ports req0 and req1, input, 1 bit each: request from requester 0 and requester 1.
REQ-005 SHALL have ports a0, b0, a1 and b1, input, W bits each: the operand pair of each requester.
REQ-006 SHALL have ports gnt0 and gnt1, output, 1 bit each: one-cycle pulse meaning the operands of that requester were captured.
REQ-007 SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse meaning result and owner are valid.
REQ-009 SHALL have port result, output, W bits: the last computed GCD.
REQ-010 SHALL have port owner, output, 1 bit: the requester that owns result.
REQ-011 SHALL have port seg, output, 7 bits: the active-low seven-segment pattern of result[3:0].

Function
REQ-012 SHALL implement a two-state FSM: IDLE and CALC.
REQ-013 In IDLE, at a rising edge with req0 or req1 high, SHALL:
- capture the winner's a into x and its b into y;
- assert that requester's gnt for exactly the following cycle;
- set last_owner to the winner;
- enter CALC.
REQ-014 Arbitration SHALL be round-robin:
- a lone requester wins;
- if both request, the requester not equal to last_owner wins.
REQ-015 Requests arriving while in CALC SHALL NOT be granted; they are evaluated at the first IDLE edge.
REQ-016 A requester SHALL hold req and its operands stable until it sees gnt, then drop req; req still high in IDLE is a new request.
REQ-017 In CALC, each rising edge SHALL apply the first matching rule:
- x==0: result<=y and finish;
- y==0: result<=x and finish;
- x==y: result<=x and finish;
- x>y: x<=x-y;
- otherwise: y<=y-x.
REQ-018 A finish SHALL do all of the following:
- load owner from last_owner;
- assert done for exactly the next cycle;
- return to IDLE.
REQ-019 Latency SHALL be exact: done is high in the cycle following the Nth CALC edge, where N = number of subtraction steps + 1.
REQ-020 A new grant MAY occur at the edge that ends the done cycle, giving back-to-back operation.
REQ-021 busy SHALL equal (state==CALC).
REQ-022 result, owner and seg SHALL hold their values until the next finish.
REQ-023 seg SHALL be registered or decoded from the result register so it changes only with result.
REQ-024 seg SHALL use this encoding, bit 6 = g ... bit 0 = a, inverted, for values 0-F:
3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71.
REQ-025 All subtractions SHALL be W-bit unsigned and SHALL NOT underflow, given the comparison order in REQ-017.
REQ-026 gcd(0,0) SHALL produce result 0.

Reset
REQ-027 On rst_n low, regardless of clk and of any in-flight computation, SHALL set:
- state=IDLE, x=0, y=0, result=0, owner=0, last_owner=1;
- gnt0=0, gnt1=0, done=0, busy=0;
- seg=7'b1000000.
REQ-028 An interrupted computation SHALL be discarded: no done pulse and no grant after reset release.
REQ-029 The first edge after reset release with rst_n high SHALL be a normal IDLE evaluation.

Verification
REQ-030 Single request: req0=1, a0=6, b0=4 ->
- gnt0 pulse;
- x,y go 6,4 -> 2,4 -> 2,2;
- done 3 cycles after gnt, result=2, owner=0, seg=7'b0100100.
REQ-031 Degenerate operands, requester 1:
- (0,7) -> result=7 one cycle after gnt;
- (5,5) -> result=5;
- (0,0) -> result=0.
REQ-032 Simultaneous requests after reset: req0=req1=1 ->
- gnt0 first;
- after its done, gnt1;
- next tie -> gnt0.
REQ-033 Worst case: a0=15, b0=1 ->
- 14 subtraction steps;
- done on the 15th cycle after gnt, result=1;
- busy high throughout CALC.
REQ-034 Request during CALC: req1 raised while busy=1 ->
- no gnt1 until the done cycle;
- gnt1 in the cycle after done.
REQ-035 Reset mid-CALC: rst_n low while computing (9,6) ->
- all outputs return to reset values immediately;
- no done pulse after release.

Source files
------------

// File: rtl/gcd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_arbiter
//  Brief    : Round-robin arbiter for two requesters in front of a
//             subtractive GCD engine, with a seven-segment result display.
//  Revision : 1.0 - initial release
// ============================================================================
module gcd_arbiter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         owner,
    output logic [6:0]   seg
);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   y_q, y_d;
    logic [W-1:0]   result_q, result_d;
    logic           owner_q, owner_d;
    logic           last_owner_q, last_owner_d;
    logic           gnt0_q, gnt0_d;
    logic           gnt1_q, gnt1_d;
    logic           done_q, done_d;
    logic           win;
    logic [W+3:0]   result_ext;
    logic [3:0]     nibble;

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        result_d     = result_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done_d       = 1'b0;
        win          = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // A tie goes to whoever did not win last; a lone request wins outright.
                    win          = (req0 && req1) ? ~last_owner_q : req1;
                    x_d          = win ? a1 : a0;
                    y_d          = win ? b1 : b0;
                    gnt0_d       = ~win;
                    gnt1_d       = win;
                    last_owner_d = win;
                    state_d      = CALC;
                end
            end
            CALC: begin
                if (x_q == '0 || y_q == '0 || x_q == y_q) begin
                    result_d = (x_q == '0) ? y_q : x_q;
                    owner_d  = last_owner_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (x_q > y_q) begin
                    x_d = x_q - y_q;
                end else begin
                    y_d = y_q - x_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            result_q     <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            result_q     <= result_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done_q       <= done_d;
        end
    end

    // Zero-extend so the low nibble exists for any operand width.
    assign result_ext = {4'b0000, result_q};
    assign nibble     = result_ext[3:0];

    always_comb begin
        seg = 7'b1000000;
        case (nibble)
            4'h0: seg = ~7'h3F;
            4'h1: seg = ~7'h06;
            4'h2: seg = ~7'h5B;
            4'h3: seg = ~7'h4F;
            4'h4: seg = ~7'h66;
            4'h5: seg = ~7'h6D;
            4'h6: seg = ~7'h7D;
            4'h7: seg = ~7'h07;
            4'h8: seg = ~7'h7F;
            4'h9: seg = ~7'h6F;
            4'hA: seg = ~7'h77;
            4'hB: seg = ~7'h7C;
            4'hC: seg = ~7'h39;
            4'hD: seg = ~7'h5E;
            4'hE: seg = ~7'h79;
            4'hF: seg = ~7'h71;
            default: seg = 7'b1000000;
        endcase
    end

    assign gnt0   = gnt0_q;
    assign gnt1   = gnt1_q;
    assign done   = done_q;
    assign busy   = (state_q == CALC);
    assign result = result_q;
    assign owner  = owner_q;

endmodule
`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcd_arbiter
//  Brief    : Directed and randomized bench for gcd_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_arbiter;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         gnt0, gnt1, busy, done, owner;
    logic [W-1:0] result;
    logic [6:0]   seg;

    int vectors = 0;
    int errors  = 0;
    bit exp_last = 1'b1;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    gcd_arbiter #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
        .result(result), .owner(owner), .seg(seg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int ref_steps(input int a, input int b);
        int n = 0;
        while (a != 0 && b != 0 && a != b) begin
            if (a > b) a = a - b; else b = b - a;
            n++;
        end
        return n;
    endfunction

    function automatic logic [6:0] ref_seg(input int v);
        logic [6:0] p;
        p = seg_tab[v % 16];
        return ~p;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_gnt"}, {30'd0, gnt1, gnt0}, 0);
        check({tag, "_done"}, {31'd0, done}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_result"}, {28'd0, result}, 0);
        check({tag, "_owner"}, {31'd0, owner}, 0);
        check({tag, "_seg"}, {25'd0, seg}, 32'h40);
    endtask

    task automatic wait_done(output int cnt, output bit gnt_seen);
        cnt = 0;
        gnt_seen = 1'b0;
        do begin
            tick();
            cnt++;
            if (gnt0 === 1'b1 || gnt1 === 1'b1) gnt_seen = 1'b1;
        end while (done !== 1'b1 && cnt < 40);
        check("done_seen", {31'd0, done}, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 1'b1;
    endtask

    // One full transaction from a single requester, checking grant, latency and result.
    task automatic do_txn(input bit who, input int a, input int b);
        int  cnt;
        bit  busy_ok;
        if (who) begin a1 = a[W-1:0]; b1 = b[W-1:0]; req1 = 1'b1; end
        else     begin a0 = a[W-1:0]; b0 = b[W-1:0]; req0 = 1'b1; end
        cnt = 0;
        do begin tick(); cnt++; end while ((who ? gnt1 : gnt0) !== 1'b1 && cnt < 8);
        check("grant_latency", cnt, 1);
        check("other_gnt", {31'd0, who ? gnt0 : gnt1}, 0);
        exp_last = who;
        if (who) req1 = 1'b0; else req0 = 1'b0;
        check("busy_in_gnt", {31'd0, busy}, 1);
        cnt = 0;
        busy_ok = 1'b1;
        do begin
            tick();
            cnt++;
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
        end while (done !== 1'b1 && cnt < 40);
        check("done_latency", cnt, ref_steps(a, b) + 1);
        check("busy_during_calc", {31'd0, busy_ok}, 1);
        check("busy_in_done", {31'd0, busy}, 0);
        check("result", {28'd0, result}, ref_gcd(a, b));
        check("owner", {31'd0, owner}, {31'd0, who});
        check("seg", {25'd0, seg}, {25'd0, ref_seg(ref_gcd(a, b))});
    endtask

    initial begin
        int  cnt;
        bit  gseen;
        bit  winner;
        int  ta, tb, tc, td;

        // Reset state
        #2;
        check_reset_outs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Single request and degenerate operands
        do_txn(1'b0, 6, 4);
        check("seg_two", {25'd0, seg}, {25'd0, 7'b0100100});
        do_txn(1'b1, 0, 7);
        do_txn(1'b1, 5, 5);
        do_txn(1'b1, 0, 0);
        do_txn(1'b0, 15, 1);

        // Ties right after reset: 0 first, then 1, then 0 again
        do_reset();
        a0 = 4'd6; b0 = 4'd4; a1 = 4'd9; b1 = 4'd6;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check("tie1_gnt", {30'd0, gnt1, gnt0}, 32'b01);
        req0 = 1'b0;
        wait_done(cnt, gseen);
        check("tie1_no_gnt_while_calc", {31'd0, gseen}, 0);
        check("tie1_owner", {31'd0, owner}, 0);
        tick();
        check("tie1_gnt1_after_done", {30'd0, gnt1, gnt0}, 32'b10);
        req1 = 1'b0;
        wait_done(cnt, gseen);
        check("tie1_result1", {28'd0, result}, 3);
        check("tie1_owner1", {31'd0, owner}, 1);
        exp_last = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check("tie2_gnt0", {30'd0, gnt1, gnt0}, 32'b01);
        req0 = 1'b0;
        wait_done(cnt, gseen);
        tick();
        check("tie2_gnt1", {30'd0, gnt1, gnt0}, 32'b10);
        req1 = 1'b0;
        wait_done(cnt, gseen);

        // Request raised during CALC waits for the IDLE edge after done
        do_txn(1'b0, 8, 8);
        a0 = 4'd9; b0 = 4'd6; req0 = 1'b1;
        tick();
        check("calcreq_gnt0", {31'd0, gnt0}, 1);
        req0 = 1'b0;
        tick();
        a1 = 4'd8; b1 = 4'd12; req1 = 1'b1;
        wait_done(cnt, gseen);
        check("calcreq_no_gnt1", {31'd0, gseen}, 0);
        check("calcreq_result", {28'd0, result}, 3);
        tick();
        check("calcreq_gnt1_after_done", {31'd0, gnt1}, 1);
        req1 = 1'b0;
        wait_done(cnt, gseen);
        check("calcreq_result1", {28'd0, result}, 4);
        check("calcreq_owner1", {31'd0, owner}, 1);

        // Reset in the middle of a computation
        a0 = 4'd9; b0 = 4'd6; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        tick();
        check("midrst_busy", {31'd0, busy}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 1'b1;
        gseen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || busy !== 1'b0) gseen = 1'b1;
        end
        check("midrst_quiet", {31'd0, gseen}, 0);

        // Randomized single-requester traffic
        for (int i = 0; i < 24; i++) begin
            do_txn(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        end

        // Randomized ties: the winner follows the round-robin model
        for (int i = 0; i < 6; i++) begin
            ta = int'($urandom_range(0, 15)); tb = int'($urandom_range(0, 15));
            tc = int'($urandom_range(0, 15)); td = int'($urandom_range(0, 15));
            a0 = ta[W-1:0]; b0 = tb[W-1:0]; a1 = tc[W-1:0]; b1 = td[W-1:0];
            req0 = 1'b1; req1 = 1'b1;
            winner = ~exp_last;
            tick();
            check("rtie_gnt", {30'd0, gnt1, gnt0}, winner ? 32'b10 : 32'b01);
            if (winner) req1 = 1'b0; else req0 = 1'b0;
            wait_done(cnt, gseen);
            check("rtie_latency", cnt, winner ? ref_steps(tc, td) + 1 : ref_steps(ta, tb) + 1);
            check("rtie_result", {28'd0, result}, winner ? ref_gcd(tc, td) : ref_gcd(ta, tb));
            tick();
            check("rtie_loser_gnt", {30'd0, gnt1, gnt0}, winner ? 32'b01 : 32'b10);
            req0 = 1'b0; req1 = 1'b0;
            exp_last = ~winner;
            wait_done(cnt, gseen);
            check("rtie_loser_owner", {31'd0, owner}, {31'd0, ~winner});
            check("rtie_loser_result", {28'd0, result}, winner ? ref_gcd(ta, tb) : ref_gcd(tc, td));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
